// File: rtl/tdm_frame_timer_pkg.sv
// rtl/tdm_frame_timer_pkg.sv - types and constants shared by the frame timer
package tdm_frame_timer_pkg;
`include "head.vh"

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [5:0] SLOT_BITS_16     = `TDM_SLOT_W16;
  localparam logic [5:0] SLOT_BITS_24     = `TDM_SLOT_W24;
  localparam logic [5:0] SLOT_BITS_32     = `TDM_SLOT_W32;
  localparam int         DEFAULT_SLOTS    = `TDM_DEFAULT_SLOTS;
  localparam logic       FSYNC_MODE_PULSE = `TDM_FSYNC_PULSE;
  localparam logic       FSYNC_MODE_HALF  = `TDM_FSYNC_HALF;

endpackage

// File: rtl/tdm_frame_timer_if.sv
// rtl/tdm_frame_timer_if.sv - configuration inputs and frame timing outputs
interface tdm_frame_timer_if #(
  parameter int MAX_SLOTS_LOG2 = 4
);
  logic                      enable;
  logic                      bclk_tick;
  logic [3:0]                tdm_num;
  logic [1:0]                slot_width_sel;
  logic                      fsync_mode;
  logic [MAX_SLOTS_LOG2:0]   tdm_num_real;
  logic [5:0]                slot_bits;
  logic                      fsync;
  logic [MAX_SLOTS_LOG2-1:0] slot_idx;
  logic [4:0]                bit_idx;
  logic                      slot_start;
  logic                      frame_start;
  logic                      cfg_err;
  logic                      running;

  modport master (
    input  enable, bclk_tick, tdm_num, slot_width_sel, fsync_mode,
    output tdm_num_real, slot_bits, fsync, slot_idx, bit_idx,
           slot_start, frame_start, cfg_err, running
  );

  modport slave (
    output enable, bclk_tick, tdm_num, slot_width_sel, fsync_mode,
    input  tdm_num_real, slot_bits, fsync, slot_idx, bit_idx,
           slot_start, frame_start, cfg_err, running
  );
endinterface

// File: rtl/head.vh
// rtl/head.vh - shared slot-width, slot-count and fsync-mode constants
`ifndef TDM_HEAD_VH
`define TDM_HEAD_VH

`define TDM_SLOT_W16      6'd16
`define TDM_SLOT_W24      6'd24
`define TDM_SLOT_W32      6'd32
`define TDM_DEFAULT_SLOTS 2
`define TDM_FSYNC_PULSE   1'b0
`define TDM_FSYNC_HALF    1'b1

`endif

// File: rtl/tdm_cfg_decode.sv
// rtl/tdm_cfg_decode.sv - register codes to real slot count and slot width
module tdm_cfg_decode
  import tdm_frame_timer_pkg::*;
#(
  parameter int MAX_SLOTS_LOG2 = 4
) (
  input  logic [3:0]              tdm_num,
  input  logic [1:0]              slot_width_sel,
  output logic [MAX_SLOTS_LOG2:0] tdm_num_real,
  output logic [5:0]              slot_bits,
  output logic                    illegal
);
  localparam int RW = MAX_SLOTS_LOG2 + 1;

  always_comb begin
    illegal      = (tdm_num == 4'd0) || (int'(tdm_num) > MAX_SLOTS_LOG2);
    tdm_num_real = illegal ? RW'(DEFAULT_SLOTS) : (RW'(1) << tdm_num);
    case (slot_width_sel)
      2'd0:    slot_bits = SLOT_BITS_16;
      2'd1:    slot_bits = SLOT_BITS_24;
      default: slot_bits = SLOT_BITS_32;
    endcase
  end
endmodule

// File: rtl/tdm_frame_timer.sv
// rtl/tdm_frame_timer.sv - TDM frame sync and slot/bit index generator
// Active configuration is reloaded only on the run-start tick and frame wrap.
module tdm_frame_timer
  import tdm_frame_timer_pkg::*;
#(
  parameter int MAX_SLOTS_LOG2 = 4,
  parameter bit FSYNC_POL      = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  tdm_frame_timer_if.master  bus
);
  localparam int SW = MAX_SLOTS_LOG2;
  localparam int RW = MAX_SLOTS_LOG2 + 1;

  state_t          state_q, state_d;
  logic [RW-1:0]   real_q, real_d, dec_real;
  logic [5:0]      bits_q, bits_d, dec_bits;
  logic            mode_q, mode_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [4:0]      bit_q, bit_d;
  logic            fs_q, fs_d;
  logic            ss_q, ss_d;
  logic            fr_q, fr_d;
  logic            err_q, dec_illegal;
  logic            load, last_bit, last_slot, fs_active;

  tdm_cfg_decode #(.MAX_SLOTS_LOG2(MAX_SLOTS_LOG2)) u_decode (
    .tdm_num        (bus.tdm_num),
    .slot_width_sel (bus.slot_width_sel),
    .tdm_num_real   (dec_real),
    .slot_bits      (dec_bits),
    .illegal        (dec_illegal)
  );

  assign last_bit  = ({1'b0, bit_q} == (bits_q - 6'd1));
  assign last_slot = ({1'b0, slot_q} == (real_q - RW'(1)));

  always_comb begin
    state_d = state_q;
    real_d  = real_q;
    bits_d  = bits_q;
    mode_d  = mode_q;
    slot_d  = slot_q;
    bit_d   = bit_q;
    ss_d    = 1'b0;
    fr_d    = 1'b0;
    load    = 1'b0;
    if (!bus.enable) begin
      state_d = ST_IDLE;
      slot_d  = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.bclk_tick) begin
            state_d = ST_RUN;
            load    = 1'b1;
            slot_d  = '0;
            bit_d   = '0;
            ss_d    = 1'b1;
            fr_d    = 1'b1;
          end
        end
        default: begin
          if (bus.bclk_tick) begin
            if (last_bit) begin
              bit_d = '0;
              ss_d  = 1'b1;
              if (last_slot) begin
                slot_d = '0;
                fr_d   = 1'b1;
                load   = 1'b1;
              end else begin
                slot_d = slot_q + SW'(1);
              end
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end
      endcase
    end
    if (load) begin
      real_d = dec_real;
      bits_d = dec_bits;
      mode_d = bus.fsync_mode;
    end
    // fsync is derived from the post-update indices so it aligns with them
    if (state_d == ST_IDLE) begin
      fs_active = 1'b0;
    end else if (mode_d == FSYNC_MODE_HALF) begin
      fs_active = ({1'b0, slot_d} < (real_d >> 1));
    end else begin
      fs_active = (slot_d == '0) && (bit_d == '0);
    end
    fs_d = fs_active ? FSYNC_POL : ~FSYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      real_q  <= RW'(DEFAULT_SLOTS);
      bits_q  <= SLOT_BITS_16;
      mode_q  <= FSYNC_MODE_PULSE;
      slot_q  <= '0;
      bit_q   <= '0;
      fs_q    <= ~FSYNC_POL;
      ss_q    <= 1'b0;
      fr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      real_q  <= real_d;
      bits_q  <= bits_d;
      mode_q  <= mode_d;
      slot_q  <= slot_d;
      bit_q   <= bit_d;
      fs_q    <= fs_d;
      ss_q    <= ss_d;
      fr_q    <= fr_d;
      err_q   <= dec_illegal;
    end
  end

  assign bus.tdm_num_real = real_q;
  assign bus.slot_bits    = bits_q;
  assign bus.fsync        = fs_q;
  assign bus.slot_idx     = slot_q;
  assign bus.bit_idx      = bit_q;
  assign bus.slot_start   = ss_q;
  assign bus.frame_start  = fr_q;
  assign bus.cfg_err      = err_q;
  assign bus.running      = (state_q == ST_RUN);
endmodule

// File: tb/tb_tdm_frame_timer.sv
// tb/tb_tdm_frame_timer.sv - self-checking bench for tdm_frame_timer
module tb_tdm_frame_timer;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_frame_timer_if #(.MAX_SLOTS_LOG2(M)) bus ();

  tdm_frame_timer #(.MAX_SLOTS_LOG2(M), .FSYNC_POL(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int   slot;
    int   bitn;
    logic fs;
    logic ss;
    logic fr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic cyc(input logic tick);
    bus.bclk_tick = tick;
    @(posedge clk);
    #1;
    bus.bclk_tick = 1'b0;
  endtask

  task automatic push_exp(input int s, input int b, input logic fs, input logic ss, input logic fr);
    exp_t e;
    e.slot = s; e.bitn = b; e.fs = fs; e.ss = ss; e.fr = fr;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.bclk_tick = 1'b0;
    bus.tdm_num = 4'd2; bus.slot_width_sel = 2'd0; bus.fsync_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.tdm_num_real !== 5'd2) begin errors++; $display("FAIL reset_real got %0d want 2", bus.tdm_num_real); end
    checks++; if (bus.slot_bits !== 6'd16) begin errors++; $display("FAIL reset_bits got %0d want 16", bus.slot_bits); end
    checks++; if (bus.fsync !== 1'b0) begin errors++; $display("FAIL reset_fsync got %b want 0", bus.fsync); end
    checks++; if (bus.slot_idx !== '0 || bus.bit_idx !== '0) begin errors++; $display("FAIL reset_idx got %0d/%0d want 0/0", bus.slot_idx, bus.bit_idx); end
    checks++; if (bus.slot_start !== 1'b0 || bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", bus.slot_start, bus.frame_start); end
    checks++; if (bus.cfg_err !== 1'b0 || bus.running !== 1'b0) begin errors++; $display("FAIL reset_err_run got %b%b want 00", bus.cfg_err, bus.running); end
    rst_n = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
  endtask

  task automatic test_basic();
    exp_t e;
    bus.enable = 1'b1;
    for (int k = 0; k <= 128; k++) begin
      push_exp((k / 16) % 4, k % 16, (k % 64) == 0, (k % 16) == 0, (k % 64) == 0);
      cyc(1'b1);
      e = exp_q.pop_front();
      checks++; if (int'(bus.slot_idx) !== e.slot) begin errors++; $display("FAIL basic_slot k=%0d got %0d want %0d", k, bus.slot_idx, e.slot); end
      checks++; if (int'(bus.bit_idx) !== e.bitn) begin errors++; $display("FAIL basic_bit k=%0d got %0d want %0d", k, bus.bit_idx, e.bitn); end
      checks++; if (bus.fsync !== e.fs) begin errors++; $display("FAIL basic_fsync k=%0d got %b want %b", k, bus.fsync, e.fs); end
      checks++; if (bus.slot_start !== e.ss) begin errors++; $display("FAIL basic_slot_start k=%0d got %b want %b", k, bus.slot_start, e.ss); end
      checks++; if (bus.frame_start !== e.fr) begin errors++; $display("FAIL basic_frame_start k=%0d got %b want %b", k, bus.frame_start, e.fr); end
    end
    checks++; if (bus.tdm_num_real !== 5'd4 || bus.slot_bits !== 6'd16) begin errors++; $display("FAIL basic_cfg got %0d/%0d want 4/16", bus.tdm_num_real, bus.slot_bits); end
    bus.enable = 1'b0;
    cyc(1'b0);
  endtask

  task automatic test_half_duty();
    exp_t e;
    int fs_cnt = 0;
    bus.tdm_num = 4'd4; bus.slot_width_sel = 2'd2; bus.fsync_mode = 1'b1;
    bus.enable = 1'b1;
    for (int k = 0; k < 512; k++) begin
      push_exp(k / 32, k % 32, k < 256, (k % 32) == 0, k == 0);
      cyc(1'b1);
      e = exp_q.pop_front();
      if (bus.fsync === 1'b1) fs_cnt++;
      checks++; if (bus.fsync !== e.fs) begin errors++; $display("FAIL half_fsync k=%0d got %b want %b", k, bus.fsync, e.fs); end
      checks++; if (int'(bus.slot_idx) !== e.slot) begin errors++; $display("FAIL half_slot k=%0d got %0d want %0d", k, bus.slot_idx, e.slot); end
      checks++; if (bus.frame_start !== e.fr) begin errors++; $display("FAIL half_frame_start k=%0d got %b want %b", k, bus.frame_start, e.fr); end
    end
    checks++; if (fs_cnt !== 256) begin errors++; $display("FAIL half_fsync_count got %0d want 256", fs_cnt); end
    checks++; if (bus.tdm_num_real !== 5'd16) begin errors++; $display("FAIL half_real got %0d want 16", bus.tdm_num_real); end
    checks++; if (bus.slot_bits !== 6'd32) begin errors++; $display("FAIL half_bits got %0d want 32", bus.slot_bits); end
    bus.enable = 1'b0; bus.fsync_mode = 1'b0; bus.slot_width_sel = 2'd0;
    cyc(1'b0);
  endtask

  task automatic test_reconfig();
    exp_t e;
    int kk;
    bus.tdm_num = 4'd1;
    bus.enable = 1'b1;
    for (int k = 0; k <= 160; k++) begin
      if (k == 20) bus.tdm_num = 4'd3;
      if (k < 32) begin
        push_exp((k / 16) % 2, k % 16, 1'b0, 1'b0, k == 0);
      end else begin
        kk = k - 32;
        push_exp((kk / 16) % 8, kk % 16, 1'b0, 1'b0, (kk % 128) == 0);
      end
      cyc(1'b1);
      e = exp_q.pop_front();
      checks++; if (int'(bus.slot_idx) !== e.slot) begin errors++; $display("FAIL reconfig_slot k=%0d got %0d want %0d", k, bus.slot_idx, e.slot); end
      checks++; if (int'(bus.bit_idx) !== e.bitn) begin errors++; $display("FAIL reconfig_bit k=%0d got %0d want %0d", k, bus.bit_idx, e.bitn); end
      checks++; if (bus.frame_start !== e.fr) begin errors++; $display("FAIL reconfig_frame_start k=%0d got %b want %b", k, bus.frame_start, e.fr); end
      if (k == 31) begin
        checks++; if (bus.tdm_num_real !== 5'd2) begin errors++; $display("FAIL reconfig_real_old got %0d want 2", bus.tdm_num_real); end
      end
      if (k == 32) begin
        checks++; if (bus.tdm_num_real !== 5'd8) begin errors++; $display("FAIL reconfig_real_new got %0d want 8", bus.tdm_num_real); end
      end
    end
    bus.enable = 1'b0;
    cyc(1'b0);
  endtask

  task automatic test_cfg_err();
    exp_t e;
    bus.tdm_num = 4'd0;
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_latency got %b want 0", bus.cfg_err); end
    cyc(1'b0);
    checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_zero got %b want 1", bus.cfg_err); end
    bus.tdm_num = 4'd9;
    cyc(1'b0);
    checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_nine got %b want 1", bus.cfg_err); end
    bus.enable = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      push_exp((k / 16) % 2, k % 16, 1'b0, 1'b0, (k % 32) == 0);
      cyc(1'b1);
      e = exp_q.pop_front();
      checks++; if (int'(bus.slot_idx) !== e.slot) begin errors++; $display("FAIL cfg_err_slot k=%0d got %0d want %0d", k, bus.slot_idx, e.slot); end
      checks++; if (bus.frame_start !== e.fr) begin errors++; $display("FAIL cfg_err_frame_start k=%0d got %b want %b", k, bus.frame_start, e.fr); end
    end
    checks++; if (bus.tdm_num_real !== 5'd2) begin errors++; $display("FAIL cfg_err_real got %0d want 2", bus.tdm_num_real); end
    bus.enable = 1'b0;
    bus.tdm_num = 4'd2;
    cyc(1'b0);
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear got %b want 0", bus.cfg_err); end
  endtask

  task automatic test_disable();
    exp_t e;
    bus.enable = 1'b1;
    for (int k = 0; k <= 37; k++) begin
      push_exp((k / 16) % 4, k % 16, 1'b0, 1'b0, 1'b0);
      cyc(1'b1);
      e = exp_q.pop_front();
      checks++; if (int'(bus.slot_idx) !== e.slot || int'(bus.bit_idx) !== e.bitn) begin errors++; $display("FAIL disable_pre k=%0d got %0d/%0d want %0d/%0d", k, bus.slot_idx, bus.bit_idx, e.slot, e.bitn); end
    end
    bus.enable = 1'b0;
    cyc(1'b1);
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL disable_running got %b want 0", bus.running); end
    checks++; if (bus.slot_idx !== '0 || bus.bit_idx !== '0) begin errors++; $display("FAIL disable_idx got %0d/%0d want 0/0", bus.slot_idx, bus.bit_idx); end
    checks++; if (bus.fsync !== 1'b0 || bus.slot_start !== 1'b0 || bus.frame_start !== 1'b0) begin errors++; $display("FAIL disable_outs got %b%b%b want 000", bus.fsync, bus.slot_start, bus.frame_start); end
    checks++; if (bus.tdm_num_real !== 5'd4) begin errors++; $display("FAIL disable_cfg_held got %0d want 4", bus.tdm_num_real); end
    bus.enable = 1'b1;
    cyc(1'b1);
    checks++; if (bus.running !== 1'b1 || bus.frame_start !== 1'b1 || bus.slot_start !== 1'b1) begin errors++; $display("FAIL restart_pulses got %b%b%b want 111", bus.running, bus.frame_start, bus.slot_start); end
    checks++; if (bus.slot_idx !== '0 || bus.bit_idx !== '0 || bus.fsync !== 1'b1) begin errors++; $display("FAIL restart_idx got %0d/%0d fs=%b want 0/0 fs=1", bus.slot_idx, bus.bit_idx, bus.fsync); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1);
      cyc(1'b0);
      cyc(1'b0);
    end
    checks++; if (bus.bit_idx !== 5'd10) begin errors++; $display("FAIL spaced_bit got %0d want 10", bus.bit_idx); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.running !== 1'b0 || bus.cfg_err !== 1'b0) begin errors++; $display("FAIL arst_run_err got %b%b want 00", bus.running, bus.cfg_err); end
    checks++; if (bus.tdm_num_real !== 5'd2 || bus.slot_bits !== 6'd16) begin errors++; $display("FAIL arst_cfg got %0d/%0d want 2/16", bus.tdm_num_real, bus.slot_bits); end
    checks++; if (bus.slot_idx !== '0 || bus.bit_idx !== '0) begin errors++; $display("FAIL arst_idx got %0d/%0d want 0/0", bus.slot_idx, bus.bit_idx); end
    checks++; if (bus.fsync !== 1'b0 || bus.slot_start !== 1'b0 || bus.frame_start !== 1'b0) begin errors++; $display("FAIL arst_outs got %b%b%b want 000", bus.fsync, bus.slot_start, bus.frame_start); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1);
    checks++; if (bus.running !== 1'b1 || bus.frame_start !== 1'b1) begin errors++; $display("FAIL post_rst_start got %b%b want 11", bus.running, bus.frame_start); end
    checks++; if (bus.slot_idx !== '0 || bus.bit_idx !== '0 || bus.tdm_num_real !== 5'd4) begin errors++; $display("FAIL post_rst_state got %0d/%0d real=%0d want 0/0 real=4", bus.slot_idx, bus.bit_idx, bus.tdm_num_real); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_half_duty();
    test_reconfig();
    test_cfg_err();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tdm_frame_timer.md
# tdm_frame_timer

Parametrised TDM frame timing generator for the i2s path. It decodes the register-level slot-count and slot-width codes into real values and counts bits and slots on a bit-clock strobe. It drives frame sync plus slot/bit indices to the serialiser and deserialiser. Configuration is shadowed so that changes take effect only on a frame boundary, and the frame never tears.

## Interface
Parameters:
- `MAX_SLOTS_LOG2`, default 4: largest supported slot count is 2^MAX_SLOTS_LOG2; legal range 1..7.
- `FSYNC_POL`, default 1: active level of `fsync`.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request, level sensitive.
- `bclk_tick` in 1: one-`clk` strobe per bit period; all counting advances only on it.
- `tdm_num` in 4: slot-count code; code n in 1..MAX_SLOTS_LOG2 selects 2^n slots; any other value selects 2 slots.
- `slot_width_sel` in 2: slot width code; 0 = 16 bits, 1 = 24, 2 = 32, 3 = 32.
- `fsync_mode` in 1: 0 = one-bit pulse, 1 = 50% duty.
- `tdm_num_real` out MAX_SLOTS_LOG2+1: active slot count.
- `slot_bits` out 6: active slot width.
- `fsync` out 1: frame sync.
- `slot_idx` out MAX_SLOTS_LOG2: current slot, 0-based.
- `bit_idx` out 5: current bit within the slot, 0 = MSB.
- `slot_start` out 1: one-`clk` pulse, first bit of each slot.
- `frame_start` out 1: one-`clk` pulse, first bit of slot 0.
- `cfg_err` out 1: pending `tdm_num` code is illegal.
- `running` out 1: state is RUN.

## Operation
- States are IDLE and RUN.
- IDLE to RUN happens on the first `bclk_tick` with `enable`=1. On that tick the block:
  - loads the pending configuration into the active shadow registers;
  - sets `slot_idx`=0 and `bit_idx`=0;
  - pulses `frame_start` and `slot_start`.
- In RUN, each `bclk_tick`:
  - increments `bit_idx`;
  - at `bit_idx`=`slot_bits`-1, wraps `bit_idx` to 0, increments `slot_idx` and pulses `slot_start`;
  - at the last bit of slot `tdm_num_real`-1, wraps to slot 0, pulses `frame_start`, and reloads the shadow configuration from the pending inputs.
- Changing `tdm_num`, `slot_width_sel` or `fsync_mode` mid-frame has no effect until the next frame boundary.
- `enable`=0 in any cycle forces IDLE on the next `clk`. When that happens:
  - indices return to 0;
  - `fsync` goes inactive and the pulses go low;
  - the active configuration is held.
- `fsync`, pulse mode: active while `slot_idx`=0 and `bit_idx`=0.
- `fsync`, 50% mode: active while `slot_idx` < `tdm_num_real`/2. With 2 slots this is exactly slot 0.
- `cfg_err`: registered decode of the pending `tdm_num`; high when the code is 0 or greater than MAX_SLOTS_LOG2. `cfg_err` is informational; the block still runs with 2 slots.
- Width rules:
  - frame length = `tdm_num_real`*`slot_bits`;
  - `tdm_num_real` = 1 << code, held in MAX_SLOTS_LOG2+1 bits so the maximum value (for example 16) fits without truncation.

## Timing
- All outputs are registered. Reset values:
  - `tdm_num_real`=2, `slot_bits`=16;
  - `fsync`=!FSYNC_POL;
  - `slot_idx`=0, `bit_idx`=0;
  - `slot_start`=0, `frame_start`=0;
  - `cfg_err`=0, `running`=0.
- Latency: a `bclk_tick` in cycle t updates the indices, `fsync` and the pulses in cycle t+1. The pulses are high for exactly one `clk`.
- `cfg_err` follows `tdm_num` with 1 `clk` latency, independent of `bclk_tick`.
- A `bclk_tick` in the same cycle as `enable` falling is ignored; the block enters IDLE.
- Back-to-back `bclk_tick`s (every `clk`) are supported, with full-rate counting.
- `rst_n` low mid-frame clears everything asynchronously. The first tick after release plus `enable`=1 starts a fresh frame.

## Structure
- Shared constants in `head.vh`, as `define`s:
  - slot width codes (16/24/32);
  - the default slot count (2);
  - the fsync mode encodings.
- One sub-module, `tdm_cfg_decode`, is natural. It is combinational and maps (`tdm_num`, `slot_width_sel`) to (real slot count, slot bits, illegal flag), parametrised by MAX_SLOTS_LOG2.
- The top level holds the FSM, the pending and active registers, the counters and the output flops.

## Test plan
- Reset, then `enable`=1, `tdm_num`=2, width code 0, tick every `clk`:
  - `frame_start` occurs every 64 ticks;
  - `slot_idx` cycles 0..3;
  - `fsync` pulse lasts 1 tick.
- `tdm_num`=4, width code 2, `fsync_mode`=1, MAX_SLOTS_LOG2=4:
  - `tdm_num_real`=16;
  - `fsync` is active for 256 of 512 ticks.
- Change `tdm_num` from 1 to 3 mid-slot 1:
  - the current frame completes as 2 slots;
  - the next `frame_start` shows `tdm_num_real`=8.
- `tdm_num`=0 or 9:
  - `cfg_err`=1 one `clk` later;
  - frames run with 2 slots.
- `enable` dropped at slot 2, bit 5:
  - next `clk` shows `running`=0, indices 0, `fsync` inactive;
  - re-enabling restarts at slot 0, bit 0.
- Assert `rst_n` low mid-frame with ticks spaced 3 `clk` apart:
  - all outputs return to their reset values immediately.
